// File: rtl/mem_io_responder_pkg.sv
// Shared address map and decode helpers for the memory/IO responder.
// Addresses are the 18 decoded bits of the CPU byte address.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;
    localparam logic [1:0]  IO_SEL  = 2'b11;

    typedef enum logic [2:0] {
        IO_R_NONE,
        IO_R_UART,
        IO_R_CNT0,
        IO_R_CNT1,
        IO_R_CNT2,
        IO_R_CNT3
    } io_reg_e;

    typedef enum logic {
        SRC_RAM,
        SRC_IO
    } rd_src_e;

    function automatic logic is_io(input logic [17:0] a);
        is_io = (a[17:16] == IO_SEL);
    endfunction

    function automatic io_reg_e decode_io(input logic [17:0] a);
        decode_io = IO_R_NONE;
        if (is_io(a)) begin
            case (a)
                IO_UART:          decode_io = IO_R_UART;
                IO_CLK:           decode_io = IO_R_CNT0;
                IO_CLK + 18'd1:   decode_io = IO_R_CNT1;
                IO_CLK + 18'd2:   decode_io = IO_R_CNT2;
                IO_CLK + 18'd3:   decode_io = IO_R_CNT3;
                default:          decode_io = IO_R_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Synchronous FIFO with occupancy count; power-of-two depth so the
// pointers wrap naturally. Pushes into a full FIFO are dropped unless a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_dout   = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage has no reset; emptiness is tracked by the count alone,
    // so clearing the pointers and count is enough to discard queued data.
    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU-side memory and IO responder: byte RAM, UART RX/TX ports, a free-running
// cycle counter with snapshot readout, and a sticky program-stop flag.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ack,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int CNT_W = $clog2(TX_DEPTH) + 1;
    localparam logic [CNT_W-1:0] NEAR_FULL = CNT_W'(TX_DEPTH - 1);

    logic [7:0]            r_ram [2**RAM_ADDR_W];
    logic [7:0]            r_ram_rd;
    rd_src_e               r_rd_src;
    logic [7:0]            r_io_rd;
    logic [31:0]           r_cnt;
    logic [31:0]           r_snap;
    logic                  r_halt;
    logic                  r_overflow;

    logic [17:0]           w_addr;
    logic [RAM_ADDR_W-1:0] w_ram_addr;
    logic                  w_is_io;
    io_reg_e               w_io_reg;
    logic                  w_io_wr;
    logic                  w_uart_wr;
    logic                  w_stop_wr;
    logic                  w_uart_rd;
    logic                  w_push;
    logic [7:0]            w_push_data;
    logic                  w_pop;
    logic [7:0]            w_fifo_dout;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [7:0]            w_io_rd_data;
    logic                  w_unused_addr;

    assign w_addr        = mem_a[17:0];
    assign w_ram_addr    = mem_a[RAM_ADDR_W-1:0];
    assign w_unused_addr = &{1'b0, mem_a[31:18]};
    assign w_is_io       = is_io(w_addr);
    assign w_io_reg      = decode_io(w_addr);

    // Once stopped, the IO write side is dead; reads and RAM keep working.
    assign w_io_wr     = mem_wr && w_is_io && !r_halt;
    assign w_uart_wr   = w_io_wr && (w_io_reg == IO_R_UART) && (mem_dout != 8'h00);
    assign w_stop_wr   = w_io_wr && (w_io_reg == IO_R_CNT0);
    assign w_uart_rd   = !mem_wr && (w_io_reg == IO_R_UART);

    assign w_push      = w_uart_wr || w_stop_wr;
    assign w_push_data = w_stop_wr ? 8'h00 : mem_dout;
    assign w_pop       = tx_valid && tx_ready;

    // The UART consumes rx_data at the edge that ends the access cycle.
    assign rx_ack = rst_in && w_uart_rd && rx_valid;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign tx_data        = w_fifo_dout;
    assign tx_valid       = !w_fifo_empty;
    assign io_buffer_full = (w_fifo_count >= NEAR_FULL);
    assign halt           = r_halt;
    assign tx_overflow    = r_overflow;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_io_rd_data = 8'h00;
        case (w_io_reg)
            IO_R_UART: w_io_rd_data = rx_valid ? rx_data : 8'h00;
            IO_R_CNT0: w_io_rd_data = r_cnt[7:0];
            IO_R_CNT1: w_io_rd_data = r_snap[15:8];
            IO_R_CNT2: w_io_rd_data = r_snap[23:16];
            IO_R_CNT3: w_io_rd_data = r_snap[31:24];
            default:   w_io_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (mem_wr && !w_is_io) begin
            r_ram[w_ram_addr] <= mem_dout;
        end
        r_ram_rd <= r_ram[w_ram_addr];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_src   <= SRC_IO;
            r_io_rd    <= 8'h00;
            r_cnt      <= 32'd0;
            r_snap     <= 32'd0;
            r_halt     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_src <= (!mem_wr && !w_is_io) ? SRC_RAM : SRC_IO;
            r_io_rd  <= mem_wr ? 8'h00 : w_io_rd_data;
            if (!r_halt) begin
                r_cnt <= r_cnt + 32'd1;
            end
            // Byte 0 is returned live; the snapshot keeps bytes 1..3 coherent.
            if (!mem_wr && (w_io_reg == IO_R_CNT0)) begin
                r_snap <= r_cnt;
            end
            if (w_stop_wr) begin
                r_halt <= 1'b1;
            end
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // RAM read data stays un-reset; the source select forces 0 during reset.
    assign mem_din = (r_rd_src == SRC_RAM) ? r_ram_rd : r_io_rd;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, counter snapshot,
// UART RX/TX paths, stop flag and mid-operation reset.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = 32'd0;
    logic [7:0]  mem_dout = 8'd0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ack;
    logic        halt;
    logic        tx_overflow;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic ack_seen;

    mem_io_responder #(
        .RAM_ADDR_W (17),
        .TX_DEPTH   (8)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ack         (rx_ack),
        .halt           (halt),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // One bus access: drive, capture rx_ack mid-cycle, then step past the edge.
    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        #1;
        ack_seen = rx_ack;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        mem_a  = 32'd0;
        mem_wr = 1'b0;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        rst_in   = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h5C;
        mem_a    = 32'h30000;
        mem_wr   = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL rst_mem_din got=%h exp=00", mem_din); end
        n_cmp++; if (rx_ack !== 1'b0) begin n_bad++; $display("FAIL rst_rx_ack got=%b exp=0", rx_ack); end
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL rst_halt got=%b exp=0", halt); end
        n_cmp++; if (tx_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%b exp=0", tx_overflow); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        n_cmp++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL rst_buf_full got=%b exp=0", io_buffer_full); end
        rx_valid = 1'b0;
        rst_in   = 1'b1;
    endtask

    task automatic test_ram();
        bus(32'h00100, 1'b1, 8'hA5);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL ram_wr_cycle got=%h exp=00", mem_din); end
        bus(32'h00100, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'hA5) begin n_bad++; $display("FAIL ram_a5 got=%h exp=a5", mem_din); end
        bus(32'h00101, 1'b1, 8'h5A);
        bus(32'h1FFFF, 1'b1, 8'hC3);
        bus(32'h00100, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'hA5) begin n_bad++; $display("FAIL ram_b2b0 got=%h exp=a5", mem_din); end
        bus(32'h00101, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h5A) begin n_bad++; $display("FAIL ram_b2b1 got=%h exp=5a", mem_din); end
        bus(32'h1FFFF, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'hC3) begin n_bad++; $display("FAIL ram_top got=%h exp=c3", mem_din); end
        bus(32'h30008, 1'b1, 8'h77);
        bus(32'h30008, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL io_other_rd got=%h exp=00", mem_din); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL io_other_wr got=%b exp=0", tx_valid); end
        bus(32'h30001, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL io_30001_rd got=%h exp=00", mem_din); end
    endtask

    task automatic test_counter();
        do_reset();
        repeat (1000) bus(32'h00000, 1'b0, 8'h00);
        bus(32'h30004, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'hE8) begin n_bad++; $display("FAIL cnt_b0 got=%h exp=e8", mem_din); end
        bus(32'h30005, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h03) begin n_bad++; $display("FAIL cnt_b1 got=%h exp=03", mem_din); end
        bus(32'h30006, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL cnt_b2 got=%h exp=00", mem_din); end
        bus(32'h30007, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL cnt_b3 got=%h exp=00", mem_din); end
        repeat (300) bus(32'h00000, 1'b0, 8'h00);
        bus(32'h30005, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h03) begin n_bad++; $display("FAIL cnt_snap_hold got=%h exp=03", mem_din); end
    endtask

    task automatic test_uart_rx();
        rx_data  = 8'h7E;
        rx_valid = 1'b1;
        bus(32'h30000, 1'b0, 8'h00);
        n_cmp++; if (ack_seen !== 1'b1) begin n_bad++; $display("FAIL rx_ack_pulse got=%b exp=1", ack_seen); end
        n_cmp++; if (mem_din !== 8'h7E) begin n_bad++; $display("FAIL rx_data got=%h exp=7e", mem_din); end
        rx_valid = 1'b0;
        bus(32'h30000, 1'b0, 8'h00);
        n_cmp++; if (ack_seen !== 1'b0) begin n_bad++; $display("FAIL rx_ack_2nd got=%b exp=0", ack_seen); end
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL rx_empty got=%h exp=00", mem_din); end
    endtask

    task automatic test_tx_fill();
        int got;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bus(32'h30000, 1'b1, 8'h41);
            n_cmp++;
            if (io_buffer_full !== (i >= 7)) begin
                n_bad++;
                $display("FAIL buf_full_after_%0d got=%b exp=%b", i, io_buffer_full, (i >= 7));
            end
        end
        n_cmp++; if (tx_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early got=%b exp=0", tx_overflow); end
        bus(32'h30000, 1'b1, 8'h41);
        n_cmp++; if (tx_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_9th got=%b exp=1", tx_overflow); end
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        tx_ready = 1'b1;
        got      = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (tx_valid === 1'b1) begin
                got++;
                n_cmp++; if (tx_data !== 8'h41) begin n_bad++; $display("FAIL tx_fill_byte got=%h exp=41", tx_data); end
            end
            @(posedge clk_in);
            #1;
        end
        tx_ready = 1'b0;
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL tx_fill_count got=%0d exp=8", got); end
        n_cmp++; if (tx_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", tx_overflow); end
    endtask

    task automatic test_fifo_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tx_ready = 1'b0;
        bus(32'h30000, 1'b1, 8'h11);
        bus(32'h30000, 1'b1, 8'h22);
        bus(32'h30000, 1'b1, 8'h33);
        tx_ready = 1'b1;
        bus(32'h30000, 1'b1, 8'h44);
        tx_ready = 1'b0;
        n_cmp++; if (tx_data !== 8'h22) begin n_bad++; $display("FAIL pushpop_head got=%h exp=22", tx_data); end
        bus(32'h30000, 1'b1, 8'h55);
        bus(32'h30000, 1'b1, 8'h66);
        bus(32'h30000, 1'b1, 8'h77);
        n_cmp++; if (io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL pushpop_cnt6 got=%b exp=0", io_buffer_full); end
        bus(32'h30000, 1'b1, 8'h88);
        n_cmp++; if (io_buffer_full !== 1'b1) begin n_bad++; $display("FAIL pushpop_cnt7 got=%b exp=1", io_buffer_full); end
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        tx_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (tx_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_cmp++; if (tx_data !== e) begin n_bad++; $display("FAIL wrap_byte got=%h exp=%h", tx_data, e); end
            end
            @(posedge clk_in);
            #1;
        end
        tx_ready = 1'b0;
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL wrap_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_halt();
        int got;
        do_reset();
        tx_ready = 1'b0;
        bus(32'h30000, 1'b1, 8'h00);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL zero_ignored got=%b exp=0", tx_valid); end
        bus(32'h30004, 1'b1, 8'h55);
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL halt_set got=%b exp=1", halt); end
        n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL halt_push got=%b exp=1", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL halt_byte got=%h exp=00", tx_data); end
        bus(32'h30004, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h02) begin n_bad++; $display("FAIL freeze_a got=%h exp=02", mem_din); end
        repeat (5) bus(32'h00000, 1'b0, 8'h00);
        bus(32'h30004, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h02) begin n_bad++; $display("FAIL freeze_b got=%h exp=02", mem_din); end
        bus(32'h30000, 1'b1, 8'h42);
        bus(32'h30004, 1'b1, 8'h99);
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        tx_ready = 1'b1;
        got      = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (tx_valid === 1'b1) begin
                got++;
                n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL halt_drain got=%h exp=00", tx_data); end
            end
            @(posedge clk_in);
            #1;
        end
        tx_ready = 1'b0;
        n_cmp++; if (got !== 1) begin n_bad++; $display("FAIL halt_drain_cnt got=%0d exp=1", got); end
        bus(32'h00300, 1'b1, 8'h66);
        bus(32'h00300, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h66) begin n_bad++; $display("FAIL halt_ram got=%h exp=66", mem_din); end
        n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL halt_sticky got=%b exp=1", halt); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL halt_cleared got=%b exp=0", halt); end
        tx_ready = 1'b0;
        bus(32'h00200, 1'b1, 8'h3C);
        bus(32'h30000, 1'b1, 8'hA1);
        bus(32'h30000, 1'b1, 8'hA2);
        bus(32'h30000, 1'b1, 8'hA3);
        repeat (495) bus(32'h00000, 1'b0, 8'h00);
        bus(32'h30004, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'hF3) begin n_bad++; $display("FAIL pre_rst_cnt got=%h exp=f3", mem_din); end
        n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_q got=%b exp=1", tx_valid); end
        mem_a = 32'd0;
        #3;
        rst_in = 1'b0;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tx got=%b exp=0", tx_valid); end
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL mid_rst_halt got=%b exp=0", halt); end
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL mid_rst_din got=%h exp=00", mem_din); end
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        bus(32'h30005, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h00) begin n_bad++; $display("FAIL snap_cleared got=%h exp=00", mem_din); end
        bus(32'h30004, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h01) begin n_bad++; $display("FAIL cnt_cleared got=%h exp=01", mem_din); end
        bus(32'h00200, 1'b0, 8'h00);
        n_cmp++; if (mem_din !== 8'h3C) begin n_bad++; $display("FAIL ram_kept got=%h exp=3c", mem_din); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL q_discarded got=%b exp=0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_counter();
        test_uart_rx();
        test_tx_fill();
        test_fifo_wrap();
        test_halt();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
